// File: rtl/phrase_scroller.sv
// Phrase window scroller: static, paged or scrolled view onto a stored phrase.
// Optional BOUNCE_EN macro enables ping-pong mode 11 (otherwise 11 acts as static).
module phrase_scroller #(
  parameter int CHAR_W = 5,
  parameter int DIGITS = 8,
  parameter int PHRASE_LEN = 16,
  parameter int TICK_DIV = 100000000,
  parameter logic [CHAR_W-1:0] BLANK = {CHAR_W{1'b1}}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [PHRASE_LEN*CHAR_W-1:0]       phrase_in,
  input  logic [1:0]                         mode,
  input  logic                               pause,
  output logic [DIGITS*CHAR_W-1:0]           display,
  output logic [$clog2(PHRASE_LEN+DIGITS)-1:0] offset,
  output logic                               step,
  output logic                               wrap
);

  localparam int L = PHRASE_LEN + DIGITS;
  localparam int OW = $clog2(L);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXB = (PHRASE_LEN > DIGITS) ? PHRASE_LEN - DIGITS : 0;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [PHRASE_LEN*CHAR_W-1:0] phrase;
  logic [CW-1:0] cnt, cnt_n;
  logic [OW-1:0] offset_n;
  logic [OW:0] page_nxt;
  logic [1:0] prev_mode;
  logic [DIGITS*CHAR_W-1:0] win;
  logic step_n, wrap_n, run;
`ifdef BOUNCE_EN
  logic dir, dir_n;
`endif

  // Stream is the phrase followed by DIGITS blanks, indexed modulo L.
  function automatic logic [CHAR_W-1:0] char_at(
    input logic [PHRASE_LEN*CHAR_W-1:0] p,
    input int k
  );
    int j;
    j = (k >= L) ? k - L : k;
    if (j < PHRASE_LEN)
      char_at = p[(PHRASE_LEN-1-j)*CHAR_W +: CHAR_W];
    else
      char_at = BLANK;
  endfunction

  always_comb begin
    win = '0;
    for (int i = 0; i < DIGITS; i++)
      win[(DIGITS-1-i)*CHAR_W +: CHAR_W] = char_at(phrase, int'(offset) + i);
  end

`ifdef BOUNCE_EN
  assign run = (mode != 2'b00);
`else
  assign run = (mode == 2'b01) || (mode == 2'b10);
`endif

  assign page_nxt = {1'b0, offset} + (OW+1)'(DIGITS);

  always_comb begin
    offset_n = offset;
    cnt_n = cnt;
    step_n = 1'b0;
    wrap_n = 1'b0;
`ifdef BOUNCE_EN
    dir_n = dir;
`endif
    if (load || (mode != prev_mode)) begin
      offset_n = '0;
      cnt_n = '0;
`ifdef BOUNCE_EN
      dir_n = 1'b1;
`endif
    end else if (!run) begin
      offset_n = '0;
      cnt_n = '0;
    end else if (!pause) begin
      if (cnt != TERM) begin
        cnt_n = cnt + 1'b1;
      end else begin
        cnt_n = '0;
        step_n = 1'b1;
        case (mode)
          2'b01: begin
            if (page_nxt >= (OW+1)'(PHRASE_LEN)) begin
              offset_n = '0;
              wrap_n = 1'b1;
            end else begin
              offset_n = page_nxt[OW-1:0];
            end
          end
          2'b10: begin
            if (offset == OW'(L - 1)) begin
              offset_n = '0;
              wrap_n = 1'b1;
            end else begin
              offset_n = offset + 1'b1;
            end
          end
`ifdef BOUNCE_EN
          2'b11: begin
            if (MAXB == 0) begin
              offset_n = '0;
            end else if (dir) begin
              offset_n = offset + 1'b1;
              if (offset + 1'b1 == OW'(MAXB)) dir_n = 1'b0;
            end else begin
              offset_n = offset - 1'b1;
              if (offset == OW'(1)) begin
                wrap_n = 1'b1;
                dir_n = 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phrase <= {PHRASE_LEN{BLANK}};
      offset <= '0;
      cnt <= '0;
      display <= {DIGITS{BLANK}};
      step <= 1'b0;
      wrap <= 1'b0;
      prev_mode <= 2'b00;
`ifdef BOUNCE_EN
      dir <= 1'b1;
`endif
    end else begin
      if (load) phrase <= phrase_in;
      offset <= offset_n;
      cnt <= cnt_n;
      display <= win;
      step <= step_n;
      wrap <= wrap_n;
      prev_mode <= mode;
`ifdef BOUNCE_EN
      dir <= dir_n;
`endif
    end
  end

endmodule
